user_frame_ctrl: RTL and testbench
==================================

Name: user_frame_ctrl

Overview:
Upstream sequencer for the player-ship sprite plotter. Once per frame it samples the left/right buttons and updates the ship X position with clamping at the screen edges. It then runs two plot passes through the downstream sprite plotter: an erase at the old position, then a draw at the new one. It owns the frame timer and the enable/done handshake with the plotter.

Parameters:
FRAME_TICKS, 833334, clk cycles per frame (50 MHz / 60 Hz); must be >= 2
X_MIN, 0, leftmost legal sprite X
X_MAX, 292, rightmost legal sprite X (320 - 28-pixel sprite width)
X_INIT, 146, X after reset
Y_POS, 200, fixed sprite Y
STEP, 1, pixels moved per frame

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
btn_left  in  1  move-left request, active high
btn_right  in  1  move-right request, active high
sprite_done  in  1  one-cycle pulse from plotter: pass complete
sprite_enable  out  1  request a plot pass; held until sprite_done
erase  out  1  current pass is an erase; downstream forces colour to 3'b000
x_pos  out  9  sprite origin X for the current pass
y_pos  out  8  sprite origin Y; constant Y_POS
frame_tick  out  1  one-cycle pulse each frame
busy  out  1  high in any state other than S_IDLE

Behaviour:
- Reset: resetn is synchronous and active-low; clock is clk. Reset wins over every other event, including mid-pass. After reset: state S_IDLE, x_pos=X_INIT, y_pos=Y_POS, sprite_enable=0, erase=0, frame_tick=0, busy=0. Frame counter=0. Pending flag=0.
- Frame timer: the counter counts 0..FRAME_TICKS-1 and wraps. frame_tick=1 in the cycle the counter equals FRAME_TICKS-1. The timer free-runs in every state.
- States:
  - S_IDLE: on frame_tick, or with pending=1, go to S_ERASE and clear pending.
  - S_ERASE: sprite_enable=1, erase=1, x_pos=old X. Leave on sprite_done to S_UPDATE.
  - S_UPDATE: one cycle, sprite_enable=0. Buttons are sampled here.
  - S_DRAW: sprite_enable=1, erase=0, x_pos=new X. Leave on sprite_done to S_IDLE.
- X update, done in S_UPDATE:
  - left only: if x >= X_MIN+STEP then x - STEP, else X_MIN.
  - right only: if x+STEP <= X_MAX then x + STEP, else X_MAX.
  - both or neither: no change.
  - Compare in 10-bit so x - STEP cannot underflow.
- Handshake: sprite_enable goes high in the first cycle of S_ERASE/S_DRAW and drops in the cycle after sprite_done is seen. sprite_done seen outside S_ERASE/S_DRAW is ignored.
- Overrun: a frame_tick while busy sets pending. At most one tick is queued; further ticks while pending=1 are dropped.
- Pass latency: one frame_tick gives 1 cycle to S_ERASE, then plotter time, then 1 cycle in S_UPDATE, then plotter time, then back to S_IDLE.

Optional Feature:
USER_BTN_SYNC_EN:
- Defined: btn_left and btn_right pass through two-flop synchronizers (reset to 0) before sampling. A button edge is visible in S_UPDATE only after 2 clk cycles.
- Undefined: buttons are sampled directly in S_UPDATE. The inputs must already be synchronous.

Test Plan:
- FRAME_TICKS=16. Reset, then release. Bench returns sprite_done 20 cycles after each enable rise. -> frame_tick at cycle 15. Erase pass at x=146 with erase=1. Draw pass at x=146 with erase=0. busy falls after the draw done.
- btn_right held for 3 frames. -> draw passes at x=147, 148, 149. Each erase pass uses the previous X.
- Start at x=1, STEP=1, btn_left held for 3 frames. -> draw X sequence 0, 0, 0; no wrap. Start at x=292 with btn_right held -> 292, 292.
- btn_left and btn_right both high. -> x unchanged; both passes still run.
- Plotter delays sprite_done by 40 cycles (longer than 2 frames). -> exactly one queued pass; the extra tick is dropped; sprite_enable is never raised while a pass is outstanding.
- Assert resetn=0 mid-S_DRAW. -> next cycle: sprite_enable=0, x_pos=146, busy=0, pending cleared.

Source files
------------

// File: rtl/user_frame_ctrl.sv
// user_frame_ctrl: per-frame ship X update and erase/draw plot sequencing; define USER_BTN_SYNC_EN to double-flop the buttons
module user_frame_ctrl #(
  parameter int FRAME_TICKS = 833334,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 292,
  parameter int X_INIT      = 146,
  parameter int Y_POS       = 200,
  parameter int STEP        = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       sprite_done,
  output logic       sprite_enable,
  output logic       erase,
  output logic [8:0] x_pos,
  output logic [7:0] y_pos,
  output logic       frame_tick,
  output logic       busy
);
  localparam int CW = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 1;
  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_UPDATE, S_DRAW} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pending_q, pending_d;
  logic [8:0] x_q, x_d;
  logic [9:0] xw;
  logic left_s, right_s;
`ifdef USER_BTN_SYNC_EN
  logic [1:0] lsync_q, lsync_d, rsync_q, rsync_d;
  always_comb begin
    lsync_d = {lsync_q[0], btn_left};
    rsync_d = {rsync_q[0], btn_right};
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lsync_q <= 2'b00;
      rsync_q <= 2'b00;
    end else begin
      lsync_q <= lsync_d;
      rsync_q <= rsync_d;
    end
  end
  assign left_s  = lsync_q[1];
  assign right_s = rsync_q[1];
`else
  assign left_s  = btn_left;
  assign right_s = btn_right;
`endif
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      x_q       <= 9'(X_INIT);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      x_q       <= x_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = (frame_tick || pending_q) ? S_ERASE : S_IDLE;
      S_ERASE:  state_d = sprite_done ? S_UPDATE : S_ERASE;
      S_UPDATE: state_d = S_DRAW;
      S_DRAW:   state_d = sprite_done ? S_IDLE : S_DRAW;
      default:  state_d = S_IDLE;
    endcase
  end
  // Leaving idle always consumes the queued tick, so pending only ever accumulates while busy.
  always_comb begin
    cnt_d     = frame_tick ? '0 : cnt_q + CW'(1);
    pending_d = (state_q == S_IDLE) ? 1'b0 : (pending_q | frame_tick);
    xw        = {1'b0, x_q};
    x_d       = x_q;
    if (state_q == S_UPDATE && (left_s ^ right_s))
      x_d = left_s ? ((xw >= 10'(X_MIN + STEP)) ? 9'(xw - 10'(STEP)) : 9'(X_MIN))
                   : ((xw + 10'(STEP) <= 10'(X_MAX)) ? 9'(xw + 10'(STEP)) : 9'(X_MAX));
  end
  always_comb begin
    frame_tick    = (cnt_q == CW'(FRAME_TICKS - 1));
    sprite_enable = (state_q == S_ERASE) || (state_q == S_DRAW);
    erase         = (state_q == S_ERASE);
    busy          = (state_q != S_IDLE);
    x_pos         = x_q;
    y_pos         = 8'(Y_POS);
  end
endmodule

// File: tb/tb_user_frame_ctrl.sv
// tb_user_frame_ctrl: table, corner-case and randomized checks of user_frame_ctrl against a clamp/pass-timing model
module tb_user_frame_ctrl;
  localparam int FT = 16;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, sprite_done = 1'b0;
  logic sprite_enable, erase, frame_tick, busy;
  logic [8:0] x_pos;
  logic [7:0] y_pos;
  int checks = 0, errors = 0;
  int tcyc = 0;
  int lat = 2;
  int due = -1;
  logic out_p = 1'b0, en_p = 1'b0, chk_on = 1'b0;

  user_frame_ctrl #(.FRAME_TICKS(FT)) dut (
    .clk(clk), .resetn(resetn), .btn_left(btn_left), .btn_right(btn_right),
    .sprite_done(sprite_done), .sprite_enable(sprite_enable), .erase(erase),
    .x_pos(x_pos), .y_pos(y_pos), .frame_tick(frame_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // cycles since the last clock edge that saw reset asserted
  always @(posedge clk) tcyc <= resetn ? tcyc + 1 : 0;

  always @(negedge clk) if (chk_on) begin
    chk("frame_tick", int'(frame_tick), int'((tcyc % FT) == FT - 1));
    chk("y_pos", int'(y_pos), 200);
  end

  // plotter model: done pulse lat cycles after each enable rise
  always @(negedge clk) begin
    sprite_done = 1'b0;
    if (!resetn) begin
      due = -1;
      out_p = 1'b0;
    end else begin
      if (sprite_enable && !en_p) begin
        chk("no_overlap", int'(out_p), 0);
        out_p = 1'b1;
        due = tcyc + lat;
      end
      if (out_p && tcyc == due) begin
        sprite_done = 1'b1;
        out_p = 1'b0;
      end
    end
    en_p = sprite_enable;
  end

  task automatic wait_pass(input logic er, input int xe, input string nm, output int t);
    logic p;
    p = sprite_enable;
    t = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sprite_enable && !p) begin
        t = tcyc;
        chk({nm, "_erase"}, int'(erase), int'(er));
        chk({nm, "_x"}, int'(x_pos), xe);
        return;
      end
      p = sprite_enable;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout got no enable rise want one", nm);
  endtask

  task automatic do_reset(input logic l, input logic r, input int lt);
    @(posedge clk); #1;
    resetn = 1'b0;
    btn_left = l;
    btn_right = r;
    lat = lt;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    chk_on = 1'b1;
  endtask

  task automatic next_frame(input logic l, input logic r, input int lt);
    @(posedge clk); #1;
    btn_left = l;
    btn_right = r;
    lat = lt;
  endtask

  function automatic int model_step(input int x, input logic l, input logic r);
    if (l && !r) return (x >= 1) ? x - 1 : 0;
    if (r && !l) return (x + 1 <= 292) ? x + 1 : 292;
    return x;
  endfunction

  typedef struct {
    logic l;
    logic r;
    int   lt;
    int   xe;
    int   xd;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int t, x;
    logic l, r;
    tbl[0] = '{1'b0, 1'b0, 20, 146, 146};
    tbl[1] = '{1'b0, 1'b1, 3, 146, 147};
    tbl[2] = '{1'b0, 1'b1, 3, 147, 148};
    tbl[3] = '{1'b0, 1'b1, 5, 148, 149};
    tbl[4] = '{1'b1, 1'b1, 2, 149, 149};
    tbl[5] = '{1'b1, 1'b0, 4, 149, 148};
    tbl[6] = '{1'b0, 1'b0, 1, 148, 148};
    tbl[7] = '{1'b1, 1'b0, 20, 148, 147};

    do_reset(tbl[0].l, tbl[0].r, tbl[0].lt);
    @(negedge clk);
    chk("rst_enable", int'(sprite_enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_erase", int'(erase), 0);
    chk("rst_x", int'(x_pos), 146);
    for (int i = 0; i < 8; i++) begin
      wait_pass(1'b1, tbl[i].xe, "tbl_erase", t);
      if (i == 0) chk("first_erase_cycle", t, 16);
      wait_pass(1'b0, tbl[i].xd, "tbl_draw", t);
      if (i == 0) chk("first_draw_cycle", t, 38);
      if (i < 7) next_frame(tbl[i + 1].l, tbl[i + 1].r, tbl[i + 1].lt);
    end

    // walk into the left edge and hold it there
    do_reset(1'b1, 1'b0, 1);
    x = 146;
    for (int i = 0; i < 149; i++) begin
      wait_pass(1'b1, x, "left_erase", t);
      x = model_step(x, 1'b1, 1'b0);
      wait_pass(1'b0, x, "left_draw", t);
    end
    chk("left_clamp", x, 0);

    do_reset(1'b0, 1'b1, 1);
    x = 146;
    for (int i = 0; i < 149; i++) begin
      wait_pass(1'b1, x, "right_erase", t);
      x = model_step(x, 1'b0, 1'b1);
      wait_pass(1'b0, x, "right_draw", t);
    end
    chk("right_clamp", x, 292);

    // random buttons and plotter latency from the right edge
    for (int i = 0; i < 80; i++) begin
      l = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      next_frame(l, r, $urandom_range(1, 6));
      wait_pass(1'b1, x, "rnd_erase", t);
      x = model_step(x, l, r);
      wait_pass(1'b0, x, "rnd_draw", t);
    end

    // slow plotter spans several ticks: exactly one extra pass is queued
    do_reset(1'b0, 1'b0, 40);
    wait_pass(1'b1, 146, "ovr_erase1", t);
    chk("ovr_erase1_cycle", t, 16);
    wait_pass(1'b0, 146, "ovr_draw1", t);
    chk("ovr_draw1_cycle", t, 58);
    next_frame(1'b0, 1'b0, 2);
    wait_pass(1'b1, 146, "ovr_erase2", t);
    chk("ovr_erase2_cycle", t, 100);
    wait_pass(1'b0, 146, "ovr_draw2", t);
    chk("ovr_draw2_cycle", t, 104);
    while (tcyc < 107) @(negedge clk);
    chk("ovr_idle_busy", int'(busy), 0);
    wait_pass(1'b1, 146, "ovr_erase3", t);
    chk("ovr_erase3_cycle", t, 112);

    // reset in the middle of a draw with a tick already queued
    do_reset(1'b1, 1'b0, 10);
    wait_pass(1'b1, 146, "mid_erase", t);
    wait_pass(1'b0, 145, "mid_draw", t);
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    btn_left = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_enable", int'(sprite_enable), 0);
    chk("mid_rst_x", int'(x_pos), 146);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_erase", int'(erase), 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    wait_pass(1'b1, 146, "mid_after_erase", t);
    chk("mid_pending_cleared", t, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
